// File: rtl/multi_audio_pkg.sv
// Shared constants for the multi-channel audio delta-sigma modulator.
//   FIFO_MARGIN        : frames of headroom kept free when 'full' is raised
//   UNDERRUN_CNT_BITS  : width of the optional underrun counter
package multi_audio_pkg;

    localparam int FIFO_MARGIN       = 3;
    localparam int UNDERRUN_CNT_BITS = 16;

endpackage

// File: rtl/multi_audio_dsm_if.sv
// Frame input bus of multi_audio_dsm.
//   data         : one PCM frame, channel k at [k*SAMPLE_BITS +: SAMPLE_BITS]
//   valid_toggle : any level change offers the frame on data
//   full/empty   : FIFO status back to the producer
//   overflow     : sticky, a frame was dropped because the FIFO was full
interface multi_audio_dsm_if #(
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_BITS = 16
);
    logic [CHANNELS*SAMPLE_BITS-1:0] data;
    logic                            valid_toggle;
    logic                            full;
    logic                            empty;
    logic                            overflow;

    modport master (output data, valid_toggle, input full, empty, overflow);
    modport slave  (input data, valid_toggle, output full, empty, overflow);
endinterface

// File: rtl/multi_audio_fifo.sv
// Synchronous FIFO with registered read data.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en/wr_data: push one word (ignored when full unless a pop happens too)
//   rd_en/rd_data: pop one word; rd_data updates on the edge that pops
//   full, empty, occupancy : status
module multi_audio_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   occupancy
);
    localparam int                  DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_OCC = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] OCC_ONE   = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (occupancy == '0);
    assign full  = (occupancy == DEPTH_OCC);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot being written.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            rd_data   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/multi_audio_dsm.sv
// Multi-channel PCM to first-order delta-sigma bitstream converter.
//   clk, reset_n         : clock, synchronous active-low reset
//   bus (slave)          : frame input, FIFO status, sticky overflow
//   factor_mul/div       : output sample rate fs/f_clk = mul/div (mul < div)
//   dsm_out              : one bitstream per channel
//   underrun_count       : only with MULTI_AUDIO_DSM_UNDERRUN_EN defined;
//                          saturating count of ticks that found the FIFO empty
module multi_audio_dsm
    import multi_audio_pkg::*;
#(
    parameter int CHANNELS           = 2,
    parameter int SAMPLE_BITS        = 16,
    parameter int FIFO_DEPTH_IN_BITS = 4,
    parameter int COUNTER_BITS       = 20,
    parameter int SIGNED_IN          = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    multi_audio_dsm_if.slave        bus,
    input  logic [COUNTER_BITS-1:0] factor_mul,
    input  logic [COUNTER_BITS-1:0] factor_div,
    output logic [CHANNELS-1:0]     dsm_out
`ifdef MULTI_AUDIO_DSM_UNDERRUN_EN
    ,
    output logic [UNDERRUN_CNT_BITS-1:0] underrun_count
`endif
);
    localparam int FRAME_BITS = CHANNELS * SAMPLE_BITS;
    localparam logic [FIFO_DEPTH_IN_BITS:0] FULL_LEVEL =
        (FIFO_DEPTH_IN_BITS+1)'((1 << FIFO_DEPTH_IN_BITS) - FIFO_MARGIN);

    logic [FRAME_BITS-1:0]         data_q;
    logic                          tog_q;
    logic                          tog_prev;
    logic                          toggle_edge;
    logic                          wr_en;
    logic                          pop;
    logic                          pop_d;
    logic                          overflow_q;
    logic [FRAME_BITS-1:0]         fifo_rd_data;
    logic [FRAME_BITS-1:0]         rd_offset;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [FIFO_DEPTH_IN_BITS:0]   occupancy;
    logic [FRAME_BITS-1:0]         hold;
    logic [COUNTER_BITS-1:0]       acc;
    logic [COUNTER_BITS:0]         acc_sum;
    logic                          tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= '0;
            tog_q    <= 1'b0;
            tog_prev <= 1'b0;
        end else begin
            data_q   <= bus.data;
            tog_q    <= bus.valid_toggle;
            tog_prev <= tog_q;
        end
    end

    assign toggle_edge  = tog_q ^ tog_prev;
    assign bus.full     = (occupancy >= FULL_LEVEL);
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow_q;
    assign wr_en        = toggle_edge && !bus.full && !fifo_full;
    assign pop          = tick && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n)                     overflow_q <= 1'b0;
        else if (toggle_edge && bus.full) overflow_q <= 1'b1;
    end

    multi_audio_fifo #(
        .WIDTH      (FRAME_BITS),
        .DEPTH_BITS (FIFO_DEPTH_IN_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (data_q),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // Fractional rate generator; acc stays below div so the wrapped value fits.
    assign acc_sum = {1'b0, acc} + {1'b0, factor_mul};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (acc_sum >= {1'b0, factor_div}) begin
            acc  <= acc_sum[COUNTER_BITS-1:0] - factor_div;
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum[COUNTER_BITS-1:0];
            tick <= 1'b0;
        end
    end

    // Two's-complement input is moved to offset binary by flipping each MSB.
    always_comb begin
        rd_offset = fifo_rd_data;
        if (SIGNED_IN != 0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                rd_offset[k*SAMPLE_BITS + SAMPLE_BITS - 1] =
                    ~fifo_rd_data[k*SAMPLE_BITS + SAMPLE_BITS - 1];
            end
        end
    end

    // rd_data is valid the cycle after the pop, so hold loads two cycles after tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pop_d <= 1'b0;
            hold  <= '0;
        end else begin
            pop_d <= pop;
            if (pop_d) hold <= rd_offset;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_dsm
        logic [SAMPLE_BITS:0] sum;
        always_ff @(posedge clk) begin
            if (!reset_n) sum <= '0;
            else          sum <= {1'b0, sum[SAMPLE_BITS-1:0]}
                                 + {1'b0, hold[k*SAMPLE_BITS +: SAMPLE_BITS]};
        end
        assign dsm_out[k] = sum[SAMPLE_BITS];
    end

`ifdef MULTI_AUDIO_DSM_UNDERRUN_EN
    localparam logic [UNDERRUN_CNT_BITS-1:0] UND_ONE = UNDERRUN_CNT_BITS'(1);

    always_ff @(posedge clk) begin
        if (!reset_n)
            underrun_count <= '0;
        else if (tick && fifo_empty && (underrun_count != '1))
            underrun_count <= underrun_count + UND_ONE;
    end
`endif
endmodule
